i2c_target_rx: RTL and testbench

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

---
 rtl/i2c_target_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// Receive-only I2C target: synchronizes SCL/SDA, ACKs its 7-bit write address and buffers one data byte.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizers.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_first,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic                   scl_sync_s, sda_sync_s;
  logic                   scl_s, sda_s;
  logic                   scl_q_r, sda_q_r;
  logic                   scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_n;
  logic [2:0] bit_cnt_r, bit_cnt_n;
  logic [6:0] shift_r, shift_n;
  logic [7:0] byte_s;
  logic       ack_on_r, ack_on_n;
  logic       first_pend_r, first_pend_n;
  logic       sda_oe_r, sda_oe_n;
  logic [7:0] rx_data_r, rx_data_n;
  logic       rx_valid_r, rx_valid_n;
  logic       rx_first_r, rx_first_n;
  logic       overflow_r, overflow_n;
  logic       busy_r, busy_n;

  assign scl_sync_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_sync_s = sda_sync_r[SYNC_STAGES-1];

  // Input synchronizers plus delayed copies for edge detection; reset to the idle-high bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_q_r    <= 1'b1;
      sda_q_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_q_r    <= scl_s;
      sda_q_r    <= sda_s;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_r, sda_hist_r;
  logic       scl_filt_r, sda_filt_r;
  logic       scl_stable_s, sda_stable_s;

  // Current sample plus two stored ones must agree before the filtered level moves
  assign scl_stable_s = (scl_hist_r == {2{scl_sync_s}});
  assign sda_stable_s = (sda_hist_r == {2{sda_sync_s}});
  assign scl_s        = scl_stable_s ? scl_sync_s : scl_filt_r;
  assign sda_s        = sda_stable_s ? sda_sync_s : sda_filt_r;

  // Sample history and held filtered level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_hist_r <= 2'b11;
      sda_hist_r <= 2'b11;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      scl_hist_r <= {scl_hist_r[0], scl_sync_s};
      sda_hist_r <= {sda_hist_r[0], sda_sync_s};
      scl_filt_r <= scl_s;
      sda_filt_r <= sda_s;
    end
  end
`else
  assign scl_s = scl_sync_s;
  assign sda_s = sda_sync_s;
`endif

  assign scl_rise_s = scl_s & ~scl_q_r;
  assign scl_fall_s = ~scl_s & scl_q_r;
  assign start_s    = scl_s & scl_q_r & sda_q_r & ~sda_s;
  assign stop_s     = scl_s & scl_q_r & ~sda_q_r & sda_s;
  assign byte_s     = {shift_r, sda_s};

  // Next-state and datapath; START/STOP override every state
  always_comb begin
    state_n      = state_r;
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    ack_on_n     = ack_on_r;
    first_pend_n = first_pend_r;
    sda_oe_n     = sda_oe_r;
    rx_data_n    = rx_data_r;
    rx_first_n   = rx_first_r;
    overflow_n   = overflow_r;
    if (rx_valid_r && rx_ready) begin
      rx_valid_n = 1'b0;
    end else begin
      rx_valid_n = rx_valid_r;
    end

    if (start_s) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      ack_on_n  = 1'b0;
    end else if (stop_s) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      ack_on_n = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s) begin
            shift_n = byte_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              if ((byte_s[7:1] == TARGET_ADDR) && !byte_s[0]) begin
                state_n      = ADDR_ACK;
                overflow_n   = 1'b0;
                first_pend_n = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // First falling edge drives the ACK low, the second one ends the ACK slot
          if (scl_fall_s) begin
            if (!ack_on_r) begin
              sda_oe_n = 1'b1;
              ack_on_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_on_n  = 1'b0;
              state_n   = DATA;
              bit_cnt_n = 3'd0;
            end
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        DATA: begin
          if (scl_rise_s) begin
            shift_n = byte_s[6:0];
            if (bit_cnt_r == 3'd7) begin
              if (!rx_valid_r || rx_ready) begin
                rx_data_n    = byte_s;
                rx_valid_n   = 1'b1;
                rx_first_n   = first_pend_r;
                first_pend_n = 1'b0;
                state_n      = DATA_ACK;
              end else begin
                overflow_n = 1'b1;
                state_n    = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          ack_on_n = 1'b0;
        end
      endcase
    end

    busy_n = (state_n == ADDR_ACK) || (state_n == DATA) || (state_n == DATA_ACK);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 7'd0;
      ack_on_r     <= 1'b0;
      first_pend_r <= 1'b0;
      sda_oe_r     <= 1'b0;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_first_r   <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      bit_cnt_r    <= bit_cnt_n;
      shift_r      <= shift_n;
      ack_on_r     <= ack_on_n;
      first_pend_r <= first_pend_n;
      sda_oe_r     <= sda_oe_n;
      rx_data_r    <= rx_data_n;
      rx_valid_r   <= rx_valid_n;
      rx_first_r   <= rx_first_n;
      overflow_r   <= overflow_n;
      busy_r       <= busy_n;
    end
  end

  assign sda_oe   = sda_oe_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign rx_first = rx_first_r;
  assign busy     = busy_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master, open-drain SDA model and a byte scoreboard.
module tb_i2c_target_rx;

  localparam int Q = 6;

  logic       clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_first;
  logic       busy;
  logic       overflow;

  int         checks;
  int         errors;
  int         oe_count;
  int         oe_mark;
  bit         prev_xfer;
  logic       ack;
  logic [8:0] exp_q[$];

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_rx #(
    .TARGET_ADDR(7'h42),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_in  (m_scl),
    .sda_in  (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_first(rx_first),
    .busy    (busy),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sda_oe"}, sda_oe, 1'b0);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_rx_first"}, rx_first, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_overflow"}, overflow, 1'b0);
  endtask

  // Sends 8 bits MSB first plus the ACK clock; ack_o is the target's SDA pull in mid-ACK
  task automatic send_byte(input logic [7:0] d, input bit rst_at_ack, input bit glitch,
                           output logic ack_o);
    for (int i = 7; i >= 0; i--) begin
      m_sda = d[i];
      tick(Q);
      m_scl = 1'b1;
      if (glitch && (i == 3)) begin
        tick(Q);
        m_scl = 1'b0;
        tick(1);
        m_scl = 1'b1;
        tick(Q - 1);
      end else begin
        tick(2 * Q);
      end
      m_scl = 1'b0;
    end
    m_sda = 1'b1;
    tick(Q);
    m_scl = 1'b1;
    tick(Q);
    ack_o = sda_oe;
    if (rst_at_ack) begin
      chk("ack_before_rst", sda_oe, 1'b1);
      rst_n = 1'b0;
      tick(1);
      check_reset_outputs("rst_mid_ack");
      rst_n = 1'b1;
      oe_mark = oe_count;
    end
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask

  // Scoreboard consumer: every accepted byte must match the next expected {first, data}
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sda_oe) oe_count++;
      if (prev_xfer) chk("valid_one_cycle", rx_valid, 1'b0);
      if (rst_n && rx_valid && rx_ready) begin
        chk("sb_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("rx_byte", {rx_first, rx_data}, exp_q.pop_front());
        prev_xfer = 1'b1;
      end else begin
        prev_xfer = 1'b0;
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    oe_count  = 0;
    oe_mark   = 0;
    prev_xfer = 1'b0;
    rst_n     = 1'b0;
    m_scl     = 1'b1;
    m_sda     = 1'b1;
    rx_ready  = 1'b1;
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_none

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // Addressed write of one byte, consumer always ready
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    chk("t1_addr_ack", ack, 1'b1);
    chk("t1_busy", busy, 1'b1);
    exp_q.push_back({1'b1, 8'hA5});
    send_byte(8'hA5, 1'b0, 1'b0, ack);
    chk("t1_data_ack", ack, 1'b1);
    i2c_stop();
    tick(4);
    chk("t1_busy_after_stop", busy, 1'b0);
    chk("t1_valid_drained", rx_valid, 1'b0);

    // Multi-byte write: only the first byte carries rx_first
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'h3C, 1'b0, 1'b0, ack);
    chk("t2_ack0", ack, 1'b1);
    exp_q.push_back({1'b0, 8'hC3});
    send_byte(8'hC3, 1'b0, 1'b0, ack);
    chk("t2_ack1", ack, 1'b1);
    i2c_stop();

    // Wrong address, then read request: never ACKed, nothing delivered
    oe_mark = oe_count;
    i2c_start();
    send_byte(8'h86, 1'b0, 1'b0, ack);
    chk("t3_addr_nack", ack, 1'b0);
    chk("t3_busy", busy, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, ack);
    chk("t3_data_nack", ack, 1'b0);
    i2c_stop();
    i2c_start();
    send_byte(8'h85, 1'b0, 1'b0, ack);
    chk("t4_read_nack", ack, 1'b0);
    chk("t4_busy", busy, 1'b0);
    i2c_stop();
    tick(2);
    chk("t34_no_sda_pull", oe_count - oe_mark, 0);
    chk("t34_no_valid", rx_valid, 1'b0);

    // Consumer stalled: second byte overflows, overflow clears on next match
    rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    exp_q.push_back({1'b1, 8'h11});
    send_byte(8'h11, 1'b0, 1'b0, ack);
    chk("t5_first_ack", ack, 1'b1);
    send_byte(8'h22, 1'b0, 1'b0, ack);
    chk("t5_overflow_nack", ack, 1'b0);
    i2c_stop();
    tick(2);
    chk("t5_overflow", overflow, 1'b1);
    chk("t5_held_valid", rx_valid, 1'b1);
    chk("t5_held_data", rx_data, 8'h11);
    chk("t5_held_first", rx_first, 1'b1);
    rx_ready = 1'b1;
    tick(3);
    chk("t5_overflow_sticky", overflow, 1'b1);
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    chk("t5_overflow_cleared", overflow, 1'b0);
    exp_q.push_back({1'b1, 8'h77});
    send_byte(8'h77, 1'b0, 1'b0, ack);
    i2c_stop();

    // Repeated START restarts addressing and re-arms rx_first
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    exp_q.push_back({1'b1, 8'h33});
    send_byte(8'h33, 1'b0, 1'b0, ack);
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    chk("t6_rs_addr_ack", ack, 1'b1);
    exp_q.push_back({1'b1, 8'h44});
    send_byte(8'h44, 1'b0, 1'b0, ack);
    chk("t6_rs_data_ack", ack, 1'b1);
    i2c_stop();

    // Reset during the address ACK, rest of the transaction ignored
    i2c_start();
    send_byte(8'h84, 1'b1, 1'b0, ack);
    send_byte(8'h99, 1'b0, 1'b0, ack);
    chk("t7_after_rst_nack", ack, 1'b0);
    i2c_stop();
    chk("t7_no_sda_pull", oe_count - oe_mark, 0);
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    chk("t7_recover_ack", ack, 1'b1);
    exp_q.push_back({1'b1, 8'hE7});
    send_byte(8'hE7, 1'b0, 1'b0, ack);
    i2c_stop();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // Short SCL low glitch inside a data bit must not add a sample
    i2c_start();
    send_byte(8'h84, 1'b0, 1'b0, ack);
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A, 1'b0, 1'b1, ack);
    chk("t8_glitch_ack", ack, 1'b1);
    i2c_stop();
`endif

    tick(5);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
